// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared uart constants and transmit-feeder FSM encoding
//
// Exports:
//   tx_state_t      : feeder FSM states (ST_IDLE, ST_LOAD, ST_WAIT_DONE)
//   DEFAULT_BAUD    : default line rate in bits per second
//   DEFAULT_CLK_HZ  : default system clock frequency in hertz
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_t;

  localparam int DEFAULT_BAUD   = 9600;
  localparam int DEFAULT_CLK_HZ = 50000000;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - generic multi-flop single-bit synchronizer
//
// Ports:
//   clk   : destination clock
//   reset : asynchronous active-low reset, flops load RESET_VAL
//   d     : asynchronous input bit
//   q     : d after STAGES destination-clock flops
module bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and load controller in front of the uart transmitter
//
// Ports:
//   clk, reset        : system clock, asynchronous active-low reset
//   wr_en, wr_data    : host byte write (one per cycle)
//   enable            : allow draining the FIFO to the uart
//   clr_err           : clears overflow and ld_err
//   tx_empty          : uart idle flag, asynchronous to clk
//   full, empty, count: FIFO status from the registered occupancy
//   ld_tx_data,tx_data: load request and byte to the uart
//   tx_enable         : enable delayed one cycle, to the uart
//   busy              : a byte is being handed over (LOAD or WAIT_DONE)
//   overflow, ld_err  : sticky error flags
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LD_TIMEOUT  = 20000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          enable,
  input  logic          clr_err,
  input  logic          tx_empty,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ld_tx_data,
  output logic [7:0]    tx_data,
  output logic          tx_enable,
  output logic          busy,
  output logic          overflow,
  output logic          ld_err
);

  localparam int TW = $clog2(LD_TIMEOUT + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic [TW-1:0] timer;
  tx_state_t     state;
  logic          txe_s;
  logic          wr_ok;
  logic          pop;

  bit_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_txe_sync (
    .clk   (clk),
    .reset (reset),
    .d     (tx_empty),
    .q     (txe_s)
  );

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  assign wr_ok = wr_en && !full;
  // Pops only happen from IDLE with data present, so the FIFO never underflows.
  assign pop   = (state == ST_IDLE) && enable && !empty && txe_s;

  // Storage has no reset; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (wr_ok) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A dropped write wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (clr_err) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_enable <= 1'b0;
    end else begin
      tx_enable <= enable;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      ld_tx_data <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      ld_err     <= 1'b0;
    end else begin
      // Clear first so a timeout in the same cycle overrides it below.
      if (clr_err) ld_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_data    <= mem[rptr];
            timer      <= '0;
            ld_tx_data <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!txe_s) begin
            // The uart has taken the byte; release the load.
            ld_tx_data <= 1'b0;
            state      <= ST_WAIT_DONE;
          end else if (timer == TW'(LD_TIMEOUT - 1)) begin
            // Uart never responded: abandon this byte rather than retry it.
            ld_tx_data <= 1'b0;
            busy       <= 1'b0;
            ld_err     <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (txe_s) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          ld_tx_data <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed self-checking bench for uart_tx_feeder
//
// Drives the feeder with host writes and a behavioural uart that drops
// tx_empty 5 cycles after a load and raises it again 100 cycles later.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       enable = 1'b0;
  logic       clr_err = 1'b0;
  logic       tx_empty = 1'b1;
  logic       full, empty, ld_tx_data, tx_enable, busy, overflow, ld_err;
  logic [4:0] count;
  logic [7:0] tx_data;

  int n_vec = 0;
  int n_err = 0;

  logic       model_en = 1'b0;
  logic [7:0] got [$];

  uart_tx_feeder #(
    .DEPTH       (16),
    .AW          (4),
    .SYNC_STAGES (2),
    .LD_TIMEOUT  (50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .enable     (enable),
    .clr_err    (clr_err),
    .tx_empty   (tx_empty),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .ld_tx_data (ld_tx_data),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
    .busy       (busy),
    .overflow   (overflow),
    .ld_err     (ld_err)
  );

  always #5 clk = ~clk;

  // Behavioural uart transmitter.
  initial begin
    forever begin
      @(negedge clk);
      if (model_en && ld_tx_data) begin
        repeat (5) @(negedge clk);
        got.push_back(tx_data);
        tx_empty = 1'b0;
        repeat (100) @(negedge clk);
        tx_empty = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    n_vec++;
    if ({full, empty, count, ld_tx_data, tx_data, tx_enable, busy, overflow, ld_err}
        !== {1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs: full=%b empty=%b count=%0d ld=%b tx_data=%h tx_en=%b busy=%b ovf=%b lderr=%b, expected 0 1 0 0 00 0 0 0 0",
               full, empty, count, ld_tx_data, tx_data, tx_enable, busy, overflow, ld_err);
    end
  endtask

  task automatic test_tx_enable();
    enable = 1'b1;
    #1;
    n_vec++;
    if (tx_enable !== 1'b0) begin
      n_err++;
      $display("FAIL tx_enable_delay: got %b expected 0", tx_enable);
    end
    cyc();
    n_vec++;
    if (tx_enable !== 1'b1) begin
      n_err++;
      $display("FAIL tx_enable_follow: got %b expected 1", tx_enable);
    end
  endtask

  task automatic test_single_byte();
    int i;
    model_en = 1'b1;
    got.delete();
    write_byte(8'hA5);
    n_vec++;
    if (ld_tx_data !== 1'b0 || count !== 5'd1) begin
      n_err++;
      $display("FAIL single_after_write: ld=%b count=%0d expected 0 1", ld_tx_data, count);
    end
    cyc();
    n_vec++;
    if (ld_tx_data !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1 || count !== 5'd0) begin
      n_err++;
      $display("FAIL single_load: ld=%b tx_data=%h busy=%b count=%0d expected 1 a5 1 0",
               ld_tx_data, tx_data, busy, count);
    end
    for (i = 0; i < 300 && busy; i++) cyc();
    n_vec++;
    if (busy !== 1'b0 || tx_empty !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: busy=%b tx_empty=%b expected 0 1", busy, tx_empty);
    end
    n_vec++;
    if (got.size() != 1 || got[0] !== 8'hA5) begin
      n_err++;
      $display("FAIL single_byte_sent: loads=%0d first=%h expected 1 a5", got.size(),
               (got.size() > 0) ? got[0] : 8'hxx);
    end
  endtask

  task automatic test_fill_overflow();
    int i;
    enable = 1'b0;
    got.delete();
    for (int b = 0; b < 16; b++) write_byte(8'(b));
    write_byte(8'hFF);
    n_vec++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1 || empty !== 1'b0) begin
      n_err++;
      $display("FAIL fill_status: full=%b count=%0d ovf=%b empty=%b expected 1 16 1 0",
               full, count, overflow, empty);
    end
    enable = 1'b1;
    for (i = 0; i < 3000 && (got.size() < 16 || busy); i++) cyc();
    n_vec++;
    if (got.size() != 16) begin
      n_err++;
      $display("FAIL drain_count: got %0d bytes expected 16", got.size());
    end
    for (int b = 0; b < 16 && b < got.size(); b++) begin
      n_vec++;
      if (got[b] !== 8'(b)) begin
        n_err++;
        $display("FAIL drain_order[%0d]: got %h expected %h", b, got[b], 8'(b));
      end
    end
    n_vec++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_err++;
      $display("FAIL drain_empty: empty=%b count=%0d expected 1 0", empty, count);
    end
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_timeout();
    int hi;
    int relaunch;
    model_en = 1'b0;
    enable   = 1'b1;
    write_byte(8'h3C);
    cyc();
    hi = 0;
    while (ld_tx_data && hi < 200) begin
      hi++;
      cyc();
    end
    n_vec++;
    if (hi != 50) begin
      n_err++;
      $display("FAIL timeout_ld_width: got %0d cycles expected 50", hi);
    end
    n_vec++;
    if (ld_err !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_flags: ld_err=%b busy=%b expected 1 0", ld_err, busy);
    end
    relaunch = 0;
    for (int k = 0; k < 10; k++) begin
      if (ld_tx_data) relaunch++;
      cyc();
    end
    n_vec++;
    if (relaunch != 0 || count !== 5'd0) begin
      n_err++;
      $display("FAIL timeout_no_retry: ld cycles=%0d count=%0d expected 0 0", relaunch, count);
    end
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    n_vec++;
    if (ld_err !== 1'b0) begin
      n_err++;
      $display("FAIL ld_err_clear: got %b expected 0", ld_err);
    end
  endtask

  task automatic test_pause();
    int i;
    int extra;
    model_en = 1'b1;
    enable   = 1'b1;
    got.delete();
    for (int b = 0; b < 4; b++) write_byte(8'h10 + 8'(b));
    for (i = 0; i < 100 && !(busy && !ld_tx_data); i++) cyc();
    n_vec++;
    if (!(busy && !ld_tx_data) || count !== 5'd3) begin
      n_err++;
      $display("FAIL pause_wait_done: busy=%b ld=%b count=%0d expected 1 0 3", busy, ld_tx_data, count);
    end
    enable = 1'b0;
    for (i = 0; i < 300 && busy; i++) cyc();
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      if (ld_tx_data) extra++;
      cyc();
    end
    n_vec++;
    if (busy !== 1'b0 || extra != 0 || count !== 5'd3 || got.size() != 1) begin
      n_err++;
      $display("FAIL pause_hold: busy=%b ld cycles=%0d count=%0d sent=%0d expected 0 0 3 1",
               busy, extra, count, got.size());
    end
    enable = 1'b1;
    for (i = 0; i < 1000 && (got.size() < 4 || busy); i++) cyc();
    n_vec++;
    if (got.size() != 4 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL resume_drain: sent=%0d empty=%b expected 4 1", got.size(), empty);
    end
    for (int b = 0; b < 4 && b < got.size(); b++) begin
      n_vec++;
      if (got[b] !== 8'h10 + 8'(b)) begin
        n_err++;
        $display("FAIL resume_order[%0d]: got %h expected %h", b, got[b], 8'h10 + 8'(b));
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int stale;
    model_en = 1'b0;
    enable   = 1'b0;
    for (int b = 0; b < 5; b++) write_byte(8'h50 + 8'(b));
    enable = 1'b1;
    cyc();
    n_vec++;
    if (ld_tx_data !== 1'b1 || count !== 5'd4 || tx_data !== 8'h50) begin
      n_err++;
      $display("FAIL pre_reset_load: ld=%b count=%0d tx_data=%h expected 1 4 50", ld_tx_data, count, tx_data);
    end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (ld_tx_data !== 1'b0 || count !== 5'd0 || tx_data !== 8'h00 || busy !== 1'b0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: ld=%b count=%0d tx_data=%h busy=%b empty=%b expected 0 0 00 0 1",
               ld_tx_data, count, tx_data, busy, empty);
    end
    repeat (2) cyc();
    reset = 1'b1;
    stale = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (ld_tx_data) stale++;
    end
    n_vec++;
    if (stale != 0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL no_stale_after_reset: ld cycles=%0d empty=%b expected 0 1", stale, empty);
    end
  endtask

  initial begin
    test_reset();
    test_tx_enable();
    test_single_byte();
    test_fill_overflow();
    test_timeout();
    test_pause();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
